reset_sequencer: RTL and testbench

- Consumes the synchronized active-high reset and turns it into an ordered release sequence.
- Peripherals (UART, VIA, RAM wrappers) are released first. The BE65C02 RESB is released after a programmable delay.
- Also handles PLL loss of lock and a soft-reset request from the monitor/debug logic.
- Sits between the reset synchronizer and every reset consumer in the top level.

---
 rtl/reset_sequencer_pkg.sv | 20 ++
 rtl/reset_sequencer_if.sv | 23 ++
 rtl/seq_counter.sv | 40 ++++
 rtl/reset_sequencer.sv | 92 +++++++++
 tb/tb_reset_sequencer.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/reset_sequencer_pkg.sv
// Shared types and defaults for the reset sequencer: state encoding,
// default timing and the counter-width helper.
package reset_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_ASSERT = 2'd0,
        ST_PERIPH = 2'd1,
        ST_RUN    = 2'd2
    } seq_state_e;

    localparam int DEF_HOLD_CYCLES = 16;
    localparam int DEF_CPU_DELAY   = 8;

    function automatic int cntWidth(input int holdCycles, input int cpuDelay);
        int maxCycles;
        maxCycles = (holdCycles > cpuDelay) ? holdCycles : cpuDelay;
        return $clog2(maxCycles) + 1;
    endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Qualifier inputs and reset outputs of the reset sequencer.
// The sequencer uses the slave modport; the top level drives the master side.
interface reset_sequencer_if;
    import reset_sequencer_pkg::*;

    logic       pll_lock;
    logic       soft_req;
    logic       periph_rst;
    logic       cpu_resb;
    logic       seq_done;
    seq_state_e seq_state;

    modport master (
        output pll_lock, soft_req,
        input  periph_rst, cpu_resb, seq_done, seq_state
    );

    modport slave (
        input  pll_lock, soft_req,
        output periph_rst, cpu_resb, seq_done, seq_state
    );

endinterface

// File: rtl/seq_counter.sv
// Qualified-cycle counter shared by the timed states. hit_o is registered and
// reports that the count loaded on the last edge equals the terminal value.
module seq_counter #(
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] tc_i,
    output logic             hit_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             hit_q, hit_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        hit_d = (cnt_d == tc_i);
    end

    // tc_i already reflects the state being entered, so the flag lines up with it
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            hit_q <= (tc_i == '0);
        end else begin
            cnt_q <= cnt_d;
            hit_q <= hit_d;
        end
    end

    assign hit_o = hit_q;

endmodule

// File: rtl/reset_sequencer.sv
// Turns the synchronized reset into an ordered release: peripherals first,
// then the 65C02 RESB after CPU_DELAY cycles; PLL loss or soft request re-sequences.
module reset_sequencer
    import reset_sequencer_pkg::*;
#(
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int CPU_DELAY   = DEF_CPU_DELAY,
    parameter int CNT_W       = cntWidth(HOLD_CYCLES, CPU_DELAY)
) (
    input logic              clk,
    input logic              reset,
    reset_sequencer_if.slave bus
);

    localparam logic [CNT_W-1:0] HOLD_TC = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CPU_TC  = CNT_W'(CPU_DELAY - 1);

    seq_state_e       state_q, state_d;
    logic             qualified;
    logic             cntClr, cntEn, cntHit;
    logic [CNT_W-1:0] cntTc;
    logic             periph_rst_q, cpu_resb_q, seq_done_q;

    assign qualified = bus.pll_lock && !bus.soft_req;

    always_comb begin
        state_d = state_q;
        cntClr  = 1'b1;
        cntEn   = 1'b0;
        unique case (state_q)
            ST_ASSERT: begin
                if (qualified) begin
                    if (cntHit) begin
                        state_d = ST_PERIPH;
                    end else begin
                        cntClr = 1'b0;
                        cntEn  = 1'b1;
                    end
                end
            end
            ST_PERIPH: begin
                if (!qualified) begin
                    state_d = ST_ASSERT;
                end else if (cntHit) begin
                    state_d = ST_RUN;
                end else begin
                    cntClr = 1'b0;
                    cntEn  = 1'b1;
                end
            end
            ST_RUN: begin
                if (!qualified) begin
                    state_d = ST_ASSERT;
                end
            end
            default: state_d = ST_ASSERT;
        endcase
        // Terminal value follows the state being entered so the counter's hit flag is valid there
        cntTc = (!reset && state_d == ST_PERIPH) ? CPU_TC : HOLD_TC;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_ASSERT;
            periph_rst_q <= 1'b1;
            cpu_resb_q   <= 1'b0;
            seq_done_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            periph_rst_q <= (state_d == ST_ASSERT);
            cpu_resb_q   <= (state_d == ST_RUN);
            seq_done_q   <= (state_d == ST_RUN);
        end
    end

    seq_counter #(
        .CNT_W(CNT_W)
    ) u_counter (
        .clk  (clk),
        .reset(reset),
        .clr_i(cntClr),
        .en_i (cntEn),
        .tc_i (cntTc),
        .hit_o(cntHit)
    );

    assign bus.periph_rst = periph_rst_q;
    assign bus.cpu_resb   = cpu_resb_q;
    assign bus.seq_done   = seq_done_q;
    assign bus.seq_state  = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: default timing (16/8) and minimum timing (1/1)
// instances run side by side on the same stimulus with hand-derived edge timelines.
module tb_reset_sequencer;

    localparam int H = 16;
    localparam int C = 8;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    bit   invOn  = 1'b0;

    reset_sequencer_if busA();
    reset_sequencer_if busB();

    reset_sequencer #(
        .HOLD_CYCLES(H),
        .CPU_DELAY  (C)
    ) dutA (
        .clk  (clk),
        .reset(reset),
        .bus  (busA.slave)
    );

    reset_sequencer #(
        .HOLD_CYCLES(1),
        .CPU_DELAY  (1)
    ) dutB (
        .clk  (clk),
        .reset(reset),
        .bus  (busB.slave)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic pl, input logic sr);
        reset         = r;
        busA.pll_lock = pl;
        busA.soft_req = sr;
        busB.pll_lock = pl;
        busB.soft_req = sr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkDut(input string tag,
                            input logic pa, input logic ca, input logic [1:0] sa,
                            input logic pb, input logic cb, input logic [1:0] sb);
        checkOutput({tag, ".A.prst"},  32'(busA.periph_rst), 32'(pa));
        checkOutput({tag, ".A.resb"},  32'(busA.cpu_resb),   32'(ca));
        checkOutput({tag, ".A.done"},  32'(busA.seq_done),   32'(ca));
        checkOutput({tag, ".A.state"}, 32'(busA.seq_state),  32'(sa));
        checkOutput({tag, ".B.prst"},  32'(busB.periph_rst), 32'(pb));
        checkOutput({tag, ".B.resb"},  32'(busB.cpu_resb),   32'(cb));
        checkOutput({tag, ".B.done"},  32'(busB.seq_done),   32'(cb));
        checkOutput({tag, ".B.state"}, 32'(busB.seq_state),  32'(sb));
    endtask

    task automatic checkHeld(input string tag);
        checkDut(tag, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 2'd0);
    endtask

    // Edge e counts qualified edges from a freshly entered ASSERT with cnt=0
    task automatic checkTimeline(input string tag, input int n);
        logic       pa, ca, pb, cb;
        logic [1:0] sa, sb;
        for (int e = 1; e <= n; e++) begin
            tick();
            pa = (e < H);
            ca = (e >= H + C);
            sa = pa ? 2'd0 : (ca ? 2'd2 : 2'd1);
            pb = 1'b0;
            cb = (e >= 2);
            sb = cb ? 2'd2 : 2'd1;
            checkDut($sformatf("%s@%0d", tag, e), pa, ca, sa, pb, cb, sb);
        end
    endtask

    always @(negedge clk) begin
        if (invOn) begin
            checkOutput("invariantA", 32'(busA.cpu_resb & busA.periph_rst), 32'd0);
            checkOutput("invariantB", 32'(busB.cpu_resb & busB.periph_rst), 32'd0);
        end
    end

    initial begin
        applyStimulus(1'b1, 1'b1, 1'b0);
        repeat (3) tick();
        checkHeld("reset");
        invOn = 1'b1;

        applyStimulus(1'b0, 1'b1, 1'b0);
        checkTimeline("normal", H + C + 2);

        applyStimulus(1'b1, 1'b1, 1'b0);
        tick();
        checkHeld("reset2");
        applyStimulus(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick();
            checkHeld($sformatf("noLock%0d", i));
        end
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkTimeline("lateLock", H + C + 2);

        applyStimulus(1'b0, 1'b0, 1'b0);
        tick();
        checkHeld("glitchRun");
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkTimeline("afterRunGlitch", H + 4);
        applyStimulus(1'b0, 1'b0, 1'b0);
        tick();
        checkHeld("glitchPeriph");
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkTimeline("afterPeriphGlitch", H + C + 2);

        applyStimulus(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 40; i++) begin
            tick();
            checkHeld($sformatf("soft%0d", i));
        end
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkTimeline("afterSoft", H + C + 2);

        applyStimulus(1'b1, 1'b1, 1'b0);
        tick();
        checkHeld("reset3");
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkTimeline("assertGlitchPre", 10);
        applyStimulus(1'b0, 1'b0, 1'b0);
        tick();
        checkHeld("glitchAssert");
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkTimeline("afterAssertGlitch", H + C + 2);

        applyStimulus(1'b1, 1'b1, 1'b0);
        tick();
        checkHeld("reset4");
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkTimeline("preMidReset", 19);
        applyStimulus(1'b1, 1'b1, 1'b0);
        tick();
        checkHeld("midReset");
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkTimeline("afterMidReset", H + C + 2);

        invOn = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
